rtc_bus_responder: RTL and testbench

- Synthesizable responder for the RTC parallel multiplexed address/data bus (a_d, cs, rd, wr).
- It is the chip side of the bus: it latches addresses, accepts data writes and returns register data on reads.
- It keeps a free-running BCD time-of-day counter, plus date, timer and control registers.
- Used as the RTC model for loopback on the FPGA and in simulation, against the existing initialization, read and write controller FSMs.

---
 rtl/rtc_bus_responder_if.sv | 28 ++
 rtl/rtc_bus_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_rtc_bus_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_responder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rtc_bus_responder_if
// Brief    : Multiplexed RTC address/data bus bundle (master drives strobes).
// Revision : 1.0 - initial release
// ============================================================================
interface rtc_bus_responder_if;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] dato_in;
    logic [7:0] dato_out;
    logic       dato_oe;
    logic [1:0] bus_estado;

    modport master (
        output a_d, cs, rd, wr, dato_in,
        input  dato_out, dato_oe, bus_estado
    );

    modport slave (
        input  a_d, cs, rd, wr, dato_in,
        output dato_out, dato_oe, bus_estado
    );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rtc_bus_responder
// Brief    : Chip-side RTC bus responder with BCD time-of-day, date, timer
//            and control registers, plus a snapshot used for coherent reads.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_responder #(
    parameter int TICK_DIV = 100000000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rtc_bus_responder_if.slave bus
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_DIV - 1);

    localparam logic [7:0] c_addr_tim_en   = 8'h00;
    localparam logic [7:0] c_addr_tim_mask = 8'h01;
    localparam logic [7:0] c_addr_status2  = 8'h02;
    localparam logic [7:0] c_addr_seg      = 8'h21;
    localparam logic [7:0] c_addr_min      = 8'h22;
    localparam logic [7:0] c_addr_hora     = 8'h23;
    localparam logic [7:0] c_addr_dia      = 8'h24;
    localparam logic [7:0] c_addr_mes      = 8'h25;
    localparam logic [7:0] c_addr_anio     = 8'h26;
    localparam logic [7:0] c_addr_seg_tim  = 8'h41;
    localparam logic [7:0] c_addr_min_tim  = 8'h42;
    localparam logic [7:0] c_addr_hora_tim = 8'h43;
    localparam logic [7:0] c_addr_transfer = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_wr;
    logic             r_bad;
    logic [7:0]       r_dato_hold;
    logic [7:0]       r_addr;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [7:0]       r_dato_out;
    logic             r_dato_oe;

    logic [7:0] r_tim_en, r_tim_mask, r_status2;
    logic [7:0] r_seg, r_min, r_hora;
    logic [7:0] r_dia, r_mes, r_anio;
    logic [7:0] r_seg_tim, r_min_tim, r_hora_tim;
    logic [7:0] r_snap_seg, r_snap_min, r_snap_hora;
    logic [7:0] r_snap_dia, r_snap_mes, r_snap_anio;

    logic       w_tick;
    logic       w_illegal;
    logic       w_rd_cond;
    logic       w_commit;
    logic       w_wr_addr;
    logic       w_wr_data;
    logic       w_wr_seg, w_wr_min, w_wr_hora;
    logic       w_seg_carry, w_min_carry;
    logic [7:0] w_rd_data;

    // Raw BCD increment: {high nibble (5 bits, may overflow), low nibble}.
    function automatic logic [8:0] bcd_raw(input logic [7:0] v);
        if (v[3:0] >= 4'd9)
            bcd_raw = {({1'b0, v[7:4]} + 5'd1), 4'd0};
        else
            bcd_raw = {1'b0, v[7:4], (v[3:0] + 4'd1)};
    endfunction

    function automatic logic bcd_wrap(input logic [7:0] v, input logic is_hora);
        logic [8:0] raw;
        raw = bcd_raw(v);
        if (is_hora)
            bcd_wrap = (raw > 9'h023);
        else
            bcd_wrap = (raw[8:4] >= 5'd6);
    endfunction

    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic is_hora);
        bcd_next = bcd_wrap(v, is_hora) ? 8'h00 : 8'(bcd_raw(v));
    endfunction

    assign w_tick    = (r_tick_cnt == c_tick_last);
    assign w_illegal = !bus.cs && !bus.rd && !bus.wr;
    // A cycle that ever showed rd and wr low together stays poisoned until cs rises.
    assign w_rd_cond = !bus.cs && bus.a_d && !bus.rd && bus.wr && !r_bad;
    assign w_commit  = !bus.cs && bus.wr && !r_wr && !r_bad;
    assign w_wr_addr = w_commit && !bus.a_d;
    assign w_wr_data = w_commit && bus.a_d;

    assign w_wr_seg  = w_wr_data && (r_addr == c_addr_seg);
    assign w_wr_min  = w_wr_data && (r_addr == c_addr_min);
    assign w_wr_hora = w_wr_data && (r_addr == c_addr_hora);

    // Carries follow the live value even when the register itself is being written.
    assign w_seg_carry = w_tick && bcd_wrap(r_seg, 1'b0);
    assign w_min_carry = w_seg_carry && bcd_wrap(r_min, 1'b0);

    always_comb begin
        w_rd_data = 8'h00;
        case (r_addr)
            c_addr_tim_en:   w_rd_data = r_tim_en;
            c_addr_tim_mask: w_rd_data = r_tim_mask;
            c_addr_status2:  w_rd_data = r_status2;
            c_addr_seg:      w_rd_data = r_snap_seg;
            c_addr_min:      w_rd_data = r_snap_min;
            c_addr_hora:     w_rd_data = r_snap_hora;
            c_addr_dia:      w_rd_data = r_snap_dia;
            c_addr_mes:      w_rd_data = r_snap_mes;
            c_addr_anio:     w_rd_data = r_snap_anio;
            c_addr_seg_tim:  w_rd_data = r_seg_tim;
            c_addr_min_tim:  w_rd_data = r_min_tim;
            c_addr_hora_tim: w_rd_data = r_hora_tim;
            default:         w_rd_data = 8'h00;
        endcase
    end

    // Bus FSM, strobe tracking and read path
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr        <= 1'b1;  // idle-high so the first cycle after reset cannot look like a commit
            r_bad       <= 1'b0;
            r_dato_hold <= 8'h00;
            r_addr      <= 8'h00;
            r_dato_out  <= 8'h00;
            r_dato_oe   <= 1'b0;
        end else begin
            r_wr <= bus.wr;

            if (bus.cs)
                r_state <= ST_IDLE;
            else if (w_illegal)
                r_state <= ST_IDLE;
            else if (!bus.a_d && !bus.wr)
                r_state <= ST_ADDR;
            else if (bus.a_d && !bus.wr)
                r_state <= ST_WR;
            else if (bus.a_d && !bus.rd)
                r_state <= ST_RD;
            else
                r_state <= ST_IDLE;

            if (bus.cs)
                r_bad <= 1'b0;
            else if (w_illegal)
                r_bad <= 1'b1;

            if (!bus.cs && !bus.wr)
                r_dato_hold <= bus.dato_in;

            if (w_wr_addr)
                r_addr <= r_dato_hold;

            if (w_rd_cond) begin
                r_dato_out <= w_rd_data;
                r_dato_oe  <= 1'b1;
            end else begin
                r_dato_oe  <= 1'b0;
            end
        end
    end

    // Tick divider, time-of-day counters, storage registers and snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_tim_en    <= 8'h00;
            r_tim_mask  <= 8'h00;
            r_status2   <= 8'h00;
            r_seg       <= 8'h00;
            r_min       <= 8'h00;
            r_hora      <= 8'h00;
            r_dia       <= 8'h00;
            r_mes       <= 8'h00;
            r_anio      <= 8'h00;
            r_seg_tim   <= 8'h00;
            r_min_tim   <= 8'h00;
            r_hora_tim  <= 8'h00;
            r_snap_seg  <= 8'h00;
            r_snap_min  <= 8'h00;
            r_snap_hora <= 8'h00;
            r_snap_dia  <= 8'h00;
            r_snap_mes  <= 8'h00;
            r_snap_anio <= 8'h00;
        end else begin
            if (w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);

            if (w_wr_seg)
                r_seg <= r_dato_hold;
            else if (w_tick)
                r_seg <= bcd_next(r_seg, 1'b0);

            if (w_wr_min)
                r_min <= r_dato_hold;
            else if (w_seg_carry)
                r_min <= bcd_next(r_min, 1'b0);

            if (w_wr_hora)
                r_hora <= r_dato_hold;
            else if (w_min_carry)
                r_hora <= bcd_next(r_hora, 1'b1);

            if (w_wr_data) begin
                case (r_addr)
                    c_addr_tim_en:   r_tim_en   <= r_dato_hold;
                    c_addr_tim_mask: r_tim_mask <= r_dato_hold;
                    c_addr_status2:  r_status2  <= r_dato_hold;
                    c_addr_dia:      r_dia      <= r_dato_hold;
                    c_addr_mes:      r_mes      <= r_dato_hold;
                    c_addr_anio:     r_anio     <= r_dato_hold;
                    c_addr_seg_tim:  r_seg_tim  <= r_dato_hold;
                    c_addr_min_tim:  r_min_tim  <= r_dato_hold;
                    c_addr_hora_tim: r_hora_tim <= r_dato_hold;
                    c_addr_transfer: begin
                        // Pre-increment values, even on a tick edge.
                        r_snap_seg  <= r_seg;
                        r_snap_min  <= r_min;
                        r_snap_hora <= r_hora;
                        r_snap_dia  <= r_dia;
                        r_snap_mes  <= r_mes;
                        r_snap_anio <= r_anio;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dato_out   = r_dato_out;
    assign bus.dato_oe    = r_dato_oe;
    assign bus.bus_estado = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rtc_bus_responder
// Brief    : Directed bench; expected read data queued at issue, popped by a
//            monitor whenever the responder starts driving the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_responder;

    localparam int TICK_DIV = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rtc_bus_responder_if bus_if ();

    rtc_bus_responder #(.TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic       prev_oe = 1'b0;
    int         tb_cnt  = 0;

    // Bench-side copy of the second divider, used only to place stimulus.
    always @(posedge clk) begin
        if (reset)
            tb_cnt <= 0;
        else if (tb_cnt == TICK_DIV - 1)
            tb_cnt <= 0;
        else
            tb_cnt <= tb_cnt + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus_if.dato_oe === 1'b1 && prev_oe !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%02h with no read outstanding", bus_if.dato_out);
            end else begin
                check(name_q.pop_front(), bus_if.dato_out, exp_q.pop_front());
            end
        end
        prev_oe = bus_if.dato_oe;
    end

    // One address or data phase: wr low (capture edge), then wr high (commit edge).
    task automatic phase(input logic ad, input logic [7:0] d);
        bus_if.cs = 1'b0; bus_if.a_d = ad; bus_if.rd = 1'b1; bus_if.wr = 1'b0;
        bus_if.dato_in = d;
        @(negedge clk);
        bus_if.wr = 1'b1;
        @(negedge clk);
    endtask

    // Five edges; the data commit lands on the fourth.
    task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
        phase(1'b0, addr);
        phase(1'b1, data);
        bus_if.cs = 1'b1;
        @(negedge clk);
    endtask

    task automatic read_reg(input logic [7:0] addr, input logic [7:0] exp, input string name);
        phase(1'b0, addr);
        bus_if.a_d = 1'b1; bus_if.wr = 1'b1; bus_if.rd = 1'b0;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        check({name, "_estado"}, {6'd0, bus_if.bus_estado}, 8'h03);
        bus_if.rd = 1'b1; bus_if.cs = 1'b1;
        @(negedge clk);
        check({name, "_oe_off"}, {7'd0, bus_if.dato_oe}, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge right after the next tick edge.
    task automatic align();
        int guard;
        guard = 0;
        @(negedge clk);
        while (tb_cnt != 0 && guard < 4 * TICK_DIV) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tb_cnt != 0) begin
            errors++;
            $display("FAIL align_timeout: tick not seen within %0d cycles", 4 * TICK_DIV);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus_if.cs = 1'b1; bus_if.a_d = 1'b0; bus_if.rd = 1'b1; bus_if.wr = 1'b1;
        bus_if.dato_in = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_oe",       {7'd0, bus_if.dato_oe},    8'h00);
        check("rst_dato_out", bus_if.dato_out,           8'h00);
        check("rst_estado",   {6'd0, bus_if.bus_estado}, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Plain storage round trip
        write_reg(8'h41, 8'h37);
        read_reg(8'h41, 8'h37, "seg_tim");

        // Aborted data phase and illegal rd+wr both leave dia untouched
        write_reg(8'h24, 8'h11);
        phase(1'b0, 8'h24);
        bus_if.a_d = 1'b1; bus_if.wr = 1'b0; bus_if.dato_in = 8'h99;
        @(negedge clk);
        bus_if.cs = 1'b1;
        @(negedge clk);
        bus_if.wr = 1'b1;
        @(negedge clk);
        bus_if.cs = 1'b0; bus_if.a_d = 1'b1; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
        bus_if.dato_in = 8'h55;
        @(negedge clk);
        check("illegal_oe_a", {7'd0, bus_if.dato_oe}, 8'h00);
        @(negedge clk);
        check("illegal_oe_b", {7'd0, bus_if.dato_oe}, 8'h00);
        bus_if.rd = 1'b1; bus_if.wr = 1'b1;
        @(negedge clk);
        check("illegal_oe_c", {7'd0, bus_if.dato_oe}, 8'h00);
        bus_if.cs = 1'b1;
        @(negedge clk);
        write_reg(8'hF0, 8'h00);
        read_reg(8'h24, 8'h11, "dia_kept");

        // 23:59:59 plus exactly one tick (at edge 16) rolls to 00:00:00
        align();
        write_reg(8'h21, 8'h59);
        write_reg(8'h22, 8'h59);
        write_reg(8'h23, 8'h23);
        write_reg(8'hF0, 8'h00);
        read_reg(8'h21, 8'h00, "roll_seg");
        read_reg(8'h22, 8'h00, "roll_min");
        read_reg(8'h23, 8'h00, "roll_hora");

        // Snapshot only refreshes on transfer: 0x10 + 3 ticks = 0x13
        align();
        write_reg(8'h21, 8'h10);
        read_reg(8'h21, 8'h00, "stale_snap");
        align();
        align();
        align();
        write_reg(8'hF0, 8'h00);
        read_reg(8'h21, 8'h13, "snap_seg13");

        // Write of seg=0x59 landing on the tick edge (edge 16): write wins, min 05->06
        align();
        write_reg(8'h22, 8'h05);
        write_reg(8'h21, 8'h59);
        idle(2);
        write_reg(8'h21, 8'h59);
        write_reg(8'hF0, 8'h00);
        read_reg(8'h21, 8'h59, "tickwr_seg");
        read_reg(8'h22, 8'h06, "tickwr_min");
        // Next tick: seg 59->00, min 06->07; then invalid 0x7A + one tick -> 00, min 07->08
        align();
        write_reg(8'h21, 8'h7A);
        align();
        write_reg(8'hF0, 8'h00);
        read_reg(8'h21, 8'h00, "bad_bcd_seg");
        read_reg(8'h22, 8'h08, "bad_bcd_min");

        // Reset in the middle of a read cycle
        phase(1'b0, 8'h41);
        bus_if.a_d = 1'b1; bus_if.wr = 1'b1; bus_if.rd = 1'b0;
        exp_q.push_back(8'h37);
        name_q.push_back("pre_reset_rd");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrd_rst_oe",       {7'd0, bus_if.dato_oe},    8'h00);
        check("midrd_rst_dato_out", bus_if.dato_out,           8'h00);
        check("midrd_rst_estado",   {6'd0, bus_if.bus_estado}, 8'h00);
        reset = 1'b0; bus_if.cs = 1'b1; bus_if.rd = 1'b1;
        @(negedge clk);
        read_reg(8'h41, 8'h00, "post_rst_seg_tim");
        write_reg(8'hF0, 8'h00);
        read_reg(8'h21, 8'h00, "post_rst_seg");
        read_reg(8'h24, 8'h00, "post_rst_dia");
        read_reg(8'h80, 8'h00, "unmapped_80");
        read_reg(8'hF0, 8'h00, "transfer_rd");

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding_reads: got %0d unanswered expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
